// File: rtl/mul_seq_if.sv
// Handshake bundle between decode and the iterative multiply sequencer.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a, b, kill,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, op, a, b, kill,
    output stall, busy, done, result
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier for mul/mulh/mulhu: magnitudes are multiplied,
// then a single sign-fix step negates the double-width product when needed.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 neg_q, neg_d;
  logic [1:0]           op_q, op_d;

  logic                 accept;
  logic                 last_iter;
  logic                 is_mulh;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   acc_fix;

  // kill overrides a same-cycle start so a flushed instruction never issues
  assign accept    = (state_q == IDLE) & bus.start & ~bus.kill;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign is_mulh   = (bus.op == 2'b01);
  assign abs_a     = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
  assign abs_b     = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
  assign acc_fix   = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC: begin
        if (bus.kill)       state_d = IDLE;
        else if (last_iter) state_d = SIGN;
      end
      SIGN:    state_d = bus.kill ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    neg_d    = neg_q;
    op_d     = op_q;
    if (accept) begin
      op_d     = bus.op;
      mcand_d  = {{WIDTH{1'b0}}, (is_mulh ? abs_a : bus.a)};
      mplier_d = is_mulh ? abs_b : bus.b;
      neg_d    = is_mulh & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == CALC) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mplier_d = mplier_q >> 1;
      mcand_d  = mcand_q << 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end else if (state_q == SIGN && !bus.kill) begin
      acc_d    = acc_fix;
      result_d = (op_q == 2'b01 || op_q == 2'b10) ? acc_fix[2*WIDTH-1:WIDTH]
                                                   : acc_fix[WIDTH-1:0];
    end
  end

  // stall is combinational on start so the PC freezes in the issue cycle
  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.done   = (state_q == DONE);
    bus.stall  = accept | (state_q == CALC) | (state_q == SIGN);
    bus.result = result_q;
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: a cycle-level reference model checked every
// cycle, plus literal expectations for each directed vector.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  mul_seq_if #(.WIDTH(32)) ifc ();

  mul_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_prod(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sp;
    logic [63:0]        up;
    logic [31:0]        r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    sp = sx * sy;
    up = {32'b0, x} * {32'b0, y};
    case (o)
      2'b01:   r = sp[63:32];
      2'b10:   r = up[63:32];
      default: r = up[31:0];
    endcase
    return r;
  endfunction

  // Model: m_age counts edges since accept; result lands 33 edges after
  // accept, done is the following cycle, and the edge after that is idle.
  logic        m_act = 1'b0;
  int          m_age = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  logic        m_stall, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_age <= 0; m_res <= '0; m_pend <= '0;
    end else if (!m_act) begin
      if (ifc.start && !ifc.kill) begin
        m_act  <= 1'b1;
        m_age  <= 1;
        m_pend <= ref_prod(ifc.op, ifc.a, ifc.b);
      end
    end else if (m_age == 34) begin
      m_act <= 1'b0;
    end else if (ifc.kill) begin
      m_act <= 1'b0;
    end else begin
      if (m_age == 33) m_res <= m_pend;
      m_age <= m_age + 1;
    end
  end

  assign m_done  = m_act && (m_age == 34);
  assign m_stall = (m_act && m_age <= 33) || (!m_act && ifc.start && !ifc.kill);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(ifc.busy), 32'(m_act));
    chk("done", 32'(ifc.done), 32'(m_done));
    chk("stall", 32'(ifc.stall), 32'(m_stall));
    chk("result", ifc.result, m_res);
    if (ifc.done) done_cnt++;
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] lit, input string nm);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.op = o; ifc.a = x; ifc.b = y;
    @(negedge clk);
    chk({nm, "_issue_stall"}, 32'(ifc.stall), 32'd1);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.done) begin
        lat = n;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd33);
    chk({nm, "_result"}, ifc.result, lit);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_idle_after"}, 32'(ifc.busy), 32'd0);
    $display("op=%0d a=%h b=%h result=%h latency=%0d", o, x, y, ifc.result, lat);
  endtask

  initial begin
    int d0;
    int seen;
    ifc.start = 1'b0; ifc.op = 2'b00; ifc.a = '0; ifc.b = '0; ifc.kill = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result", ifc.result, 32'h0);
    chk("reset_busy", 32'(ifc.busy), 32'd0);

    run_op(2'b00, 32'd7, 32'd6, 32'h0000002A, "mul_7x6");

    // kill in the 10th CALC cycle: no done, result keeps 0x2A
    d0 = done_cnt;
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.op = 2'b00; ifc.a = 32'd100; ifc.b = 32'd100;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 ifc.kill = 1'b1;
    @(posedge clk); #1;
    ifc.kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", 32'(ifc.busy), 32'd0);
    chk("kill_stall", 32'(ifc.stall), 32'd0);
    chk("kill_result", ifc.result, 32'h0000002A);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("kill_no_done", 32'(done_cnt - d0), 32'd0);
    $display("kill mid-CALC: busy=%0d result=%h", ifc.busy, ifc.result);

    run_op(2'b00, 32'd3, 32'd5, 32'h0000000F, "mul_after_kill");

    // kill beats start in IDLE
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.kill = 1'b1; ifc.a = 32'd9; ifc.b = 32'd9;
    @(negedge clk);
    chk("idle_kill_stall", 32'(ifc.stall), 32'd0);
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.kill = 1'b0;
    @(negedge clk);
    chk("idle_kill_busy", 32'(ifc.busy), 32'd0);
    $display("start+kill in IDLE: busy=%0d", ifc.busy);

    run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulh_m1x2");
    run_op(2'b10, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, "mulhu_m1x2");
    run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, "mul_m1x2");
    run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min_min");
    run_op(2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, "mulh_min_1");
    run_op(2'b11, 32'h00010000, 32'h00010003, 32'h00030000, "op11_as_mul");

    // start held with operands changing every cycle after the first accept
    d0 = done_cnt;
    seen = 0;
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.op = 2'b00; ifc.a = 32'd3; ifc.b = 32'd4;
    @(posedge clk);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      ifc.a = 32'(i * 3 + 1);
      ifc.b = 32'(i + 7);
      @(negedge clk);
      if (ifc.done) begin
        seen++;
        if (seen == 1) chk("held_first_result", ifc.result, 32'd12);
        if (seen == 2) chk("held_second_result", ifc.result, 32'h00000FA0);
        $display("held-start done #%0d result=%h", seen, ifc.result);
      end
    end
    ifc.start = 1'b0;
    chk("held_done_count", 32'(done_cnt - d0), 32'd2);
    for (int n = 0; n < 60 && ifc.busy; n++) @(negedge clk);
    chk("held_drain_busy", 32'(ifc.busy), 32'd0);

    // asynchronous reset between edges in the middle of CALC
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.op = 2'b00; ifc.a = 32'd5; ifc.b = 32'd5;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(ifc.busy), 32'd0);
    chk("arst_stall", 32'(ifc.stall), 32'd0);
    chk("arst_done", 32'(ifc.done), 32'd0);
    chk("arst_result", ifc.result, 32'h0);
    $display("async reset mid-CALC: busy=%0d result=%h", ifc.busy, ifc.result);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_after_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative multiply sequencer for the RV32 core's M-subset ops: mul, mulh, mulhu.
- Sits beside the single-cycle ALU. Decode issues a multiply to it, and it stalls the PC/pipeline until the result is ready.
- Uses radix-2 shift-add on operand magnitudes, with a final sign-fix step. The result is muxed into the writeback path on the done cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  multiply request from decode (aluop is a multiply and regwrite=1).
- op  in  2  00=mul (low word), 01=mulh (signed×signed, high word), 10=mulhu (unsigned×unsigned, high word), 11=treated as mul.
- a  in  WIDTH  rs1 operand.
- b  in  WIDTH  rs2 operand.
- kill  in  1  abort the in-flight operation (pipeline flush).
- stall  out  1  freeze PC/fetch/decode this cycle.
- busy  out  1  sequencer not in IDLE.
- done  out  1  one-cycle pulse; result valid for writeback.
- result  out  WIDTH  selected product word.

Behaviour:
- States: IDLE, CALC, SIGN, DONE (2-bit encoding).
- Reset (rst_n low, async):
  - state=IDLE, counter=0, accumulator/multiplicand/multiplier regs=0, neg flag=0, op reg=00.
  - result=0; done=0, busy=0.
  - stall=0 except through the combinational start term below.
- IDLE:
  - start=1 accepts on the rising edge (edge E0).
  - Latch op.
  - Multiplicand/multiplier:
    - mulh: |a| and |b| as WIDTH-bit unsigned (0x80000000 stays 0x80000000).
    - mulhu and mul: a and b unchanged.
  - neg = (op==01) & (a[WIDTH-1]^b[WIDTH-1]).
  - Clear the 2*WIDTH accumulator, set counter=0, go to CALC.
- CALC, one multiplier bit per cycle:
  - If multiplier LSB is 1, add the shifted multiplicand into the accumulator.
  - Shift multiplier right and multiplicand left; counter+1.
  - After WIDTH iterations (edges E1..E32), go to SIGN.
- SIGN (edge E33):
  - If neg, the 2*WIDTH accumulator becomes its two's complement.
  - Register result = op==01 or 10 ? acc[2W-1:W] : acc[W-1:0].
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: done is high in the cycle following E33, i.e. 33 cycles after the accept edge.
- Result hold: result holds its value after done until the next SIGN update. It is not cleared on return to IDLE.
- Outputs:
  - busy = (state != IDLE).
  - stall = (state==IDLE & start) | state==CALC | state==SIGN. This is combinational so the PC freezes in the issue cycle.
  - stall=0 in DONE so the pipeline advances and captures result the same cycle.
- start while busy: ignored, no queueing. Decode cannot issue because it is stalled; the bench checks the sequencer ignores it anyway.
- kill:
  - In CALC or SIGN: next edge → IDLE, no done pulse, result unchanged, stall drops the cycle after.
  - In DONE: the done pulse still completes (writeback already committed).
  - In IDLE with start=1: kill wins, no accept, stall=0.
- Reset mid-operation: immediate IDLE, all outputs to reset values, no done.
- Arithmetic:
  - Accumulator is 2*WIDTH bits, unsigned adds, no overflow possible.
  - Low word of mul is identical for signed and unsigned inputs, so mul uses the unsigned path.
- Back-to-back: a new start may be accepted in the IDLE cycle directly after DONE (2 cycles between accepts minimum beyond latency).

Test Plan:
- Basic mul: reset, start op=00 a=7 b=6 → stall high from the issue cycle; done exactly 33 cycles after accept, result=0x0000002A, busy low the next cycle.
- mulh vs mulhu on the same operands:
  - op=01 a=0xFFFFFFFF b=0x00000002 → result=0xFFFFFFFF.
  - op=10, same operands → result=0x00000001.
  - op=00, same operands → result=0xFFFFFFFE.
- mulh corner: a=0x80000000 b=0x80000000 op=01 → result=0x40000000; a=0x80000000 b=0x00000001 op=01 → result=0xFFFFFFFF.
- kill at cycle 10 of CALC:
  - Returns to IDLE next edge, done never pulses, result keeps its prior value (0x2A from the earlier test).
  - A following start a=3 b=5 op=00 gives result=0x0000000F.
- start held high throughout an operation with changing a/b → only the first accept is used; exactly one done per accept, and a new accept only in IDLE after DONE.
- rst_n asserted mid-CALC asynchronously (between edges) → busy/stall/done/result go to 0 immediately; first op after release is correct (a=0xFFFFFFFF b=0xFFFFFFFF op=10 → 0xFFFFFFFE).
